// File: rtl/datapath.sv
// Accumulator datapath: ADDI/LDI/MOVB/OUT on A, B and carry C, with a small
// output FIFO whose pushes are dropped (sticky overflow) when full and not draining.
module datapath #(
   parameter int DATA_WIDTH   = 4,
   parameter int INST_WIDTH   = 8,
   parameter int OPCODE_WIDTH = 2,
   parameter int FIFO_DEPTH   = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [INST_WIDTH-1:0] inst,
   output logic                  alu_cout,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  overflow
);

   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

   logic [OPCODE_WIDTH-1:0] opcode;
   logic [1:0]              funct;
   logic [DATA_WIDTH-1:0]   imm;
   logic [DATA_WIDTH:0]     sum;

   logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic                  c_q, c_d;
   logic [DATA_WIDTH-1:0] ent_q [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] ent_d [FIFO_DEPTH];
   logic [CW-1:0]         cnt_q, cnt_d, wr_idx;
   logic                  ovf_q, ovf_d;
   logic                  push, pop, push_ok;

   assign opcode = inst[INST_WIDTH-1 -: OPCODE_WIDTH];
   assign funct  = inst[INST_WIDTH-OPCODE_WIDTH-1 -: 2];
   assign imm    = inst[DATA_WIDTH-1:0];
   assign sum    = {1'b0, a_q} + {1'b0, imm};

   always_comb begin
      a_d  = a_q;
      b_d  = b_q;
      c_d  = c_q;
      push = 1'b0;
      if (opcode == '0) begin
         unique case (funct)
            2'b00:   {c_d, a_d} = sum;
            2'b01:   a_d = imm;
            2'b10:   b_d = a_q;
            default: push = 1'b1;
         endcase
      end
   end

   // Shift-register FIFO: entry 0 is the head, a pop shifts before the write lands.
   assign pop     = (cnt_q != '0) && out_ready;
   assign push_ok = push && ((cnt_q != FULL) || pop);
   assign wr_idx  = cnt_q - {{(CW-1){1'b0}}, pop};

   always_comb begin
      ent_d = ent_q;
      ovf_d = ovf_q;
      if (pop) begin
         for (int i = 0; i < FIFO_DEPTH - 1; i++) ent_d[i] = ent_q[i+1];
      end
      if (push_ok) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (CW'(i) == wr_idx) ent_d[i] = a_q;
         end
      end else if (push) begin
         ovf_d = 1'b1;
      end
      cnt_d = cnt_q + {{(CW-1){1'b0}}, push_ok} - {{(CW-1){1'b0}}, pop};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q   <= '0;
         b_q   <= '0;
         c_q   <= 1'b0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) ent_q[i] <= '0;
      end else begin
         a_q   <= a_d;
         b_q   <= b_d;
         c_q   <= c_d;
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
         ent_q <= ent_d;
      end
   end

   assign alu_cout  = c_q;
   assign out_data  = ent_q[0];
   assign out_valid = (cnt_q != '0);
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_datapath.sv
// Bench for datapath: a queue-based model checked every cycle, plus directed
// vectors with hand-computed literal expectations.
module tb_datapath;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] inst = 8'hC0;
   logic       out_ready = 1'b0;
   logic       alu_cout, out_valid, overflow;
   logic [3:0] out_data;

   int nchk = 0;
   int nerr = 0;
   bit chk_en = 1'b0;

   int ma, mb, mc, movf;
   int q[$];

   datapath dut (
      .clk(clk), .rst(rst), .inst(inst), .alu_cout(alu_cout),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .overflow(overflow)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] ldi(input int v);  return {4'b0001, 4'(v)}; endfunction
   function automatic logic [7:0] addi(input int v); return {4'b0000, 4'(v)}; endfunction
   localparam logic [7:0] MOVB = 8'h20;
   localparam logic [7:0] OUTI = 8'h30;
   localparam logic [7:0] NOP  = 8'hC0;

   task automatic check(input string name, input int act, input int exp);
      nchk++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: spec rules on plain ints and a queue.
   always @(posedge clk) begin
      int  s;
      bit  do_pop, do_push;
      if (rst) begin
         ma = 0; mb = 0; mc = 0; movf = 0;
         q.delete();
      end else begin
         do_pop  = (q.size() > 0) && out_ready;
         do_push = 1'b0;
         if (inst[7:6] == 2'b00) begin
            case (inst[5:4])
               2'b00: begin s = ma + int'(inst[3:0]); mc = (s >= 16); ma = s % 16; end
               2'b01: ma = int'(inst[3:0]);
               2'b10: mb = ma;
               default: do_push = 1'b1;
            endcase
         end
         if (do_push && !(q.size() < 2 || do_pop)) begin
            movf = 1;
            do_push = 1'b0;
         end
         if (do_pop) void'(q.pop_front());
         if (do_push) q.push_back(ma);
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("cout", int'(alu_cout), mc);
         check("valid", int'(out_valid), int'(q.size() > 0));
         check("overflow", int'(overflow), movf);
         if (q.size() > 0) check("data", int'(out_data), q[0]);
         check("regA", int'(dut.a_q), ma);
         check("regB", int'(dut.b_q), mb);
      end
   end

   task automatic step(input logic [7:0] i, input logic rdy, input logic r);
      inst = i; out_ready = rdy; rst = r;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #1;
      step(NOP, 1'b0, 1'b1);
      step(NOP, 1'b0, 1'b1);
      chk_en = 1'b1;
      check("rst_valid", int'(out_valid), 0);
      check("rst_ovf", int'(overflow), 0);
      check("rst_data", int'(out_data), 0);
      check("rst_cout", int'(alu_cout), 0);

      // carry generation and clearing
      step(ldi(9), 1'b0, 1'b0);
      step(addi(9), 1'b0, 1'b0);
      check("addi_wrap_A", int'(dut.a_q), 2);
      check("addi_wrap_C", int'(alu_cout), 1);
      step(addi(1), 1'b0, 1'b0);
      check("addi_A", int'(dut.a_q), 3);
      check("addi_C", int'(alu_cout), 0);

      // MOVB with C preset to 1
      step(ldi(9), 1'b0, 1'b0);
      step(addi(9), 1'b0, 1'b0);
      step(ldi(5), 1'b0, 1'b0);
      step(MOVB, 1'b0, 1'b0);
      step(ldi(0), 1'b0, 1'b0);
      check("movb_B", int'(dut.b_q), 5);
      check("movb_A", int'(dut.a_q), 0);
      check("movb_C", int'(alu_cout), 1);

      // overflow on third OUT with consumer stalled
      step(ldi(1), 1'b0, 1'b0);
      step(OUTI, 1'b0, 1'b0);
      check("no_fallthru_valid", int'(out_valid), 1);
      step(ldi(2), 1'b0, 1'b0);
      step(OUTI, 1'b0, 1'b0);
      step(ldi(3), 1'b0, 1'b0);
      step(OUTI, 1'b0, 1'b0);
      check("ovf_set", int'(overflow), 1);
      check("ovf_head", int'(out_data), 1);
      step(NOP, 1'b1, 1'b0);
      check("drain_2", int'(out_data), 2);
      step(NOP, 1'b1, 1'b0);
      check("drain_empty", int'(out_valid), 0);
      step(NOP, 1'b1, 1'b0);
      check("ovf_sticky", int'(overflow), 1);

      // push+pop while full
      step(NOP, 1'b0, 1'b1);
      step(ldi(1), 1'b0, 1'b0);
      step(OUTI, 1'b0, 1'b0);
      step(ldi(2), 1'b0, 1'b0);
      step(OUTI, 1'b0, 1'b0);
      step(ldi(7), 1'b0, 1'b0);
      step(OUTI, 1'b1, 1'b0);
      check("fullpp_ovf", int'(overflow), 0);
      check("fullpp_head", int'(out_data), 2);
      step(NOP, 1'b1, 1'b0);
      check("fullpp_third", int'(out_data), 7);
      step(NOP, 1'b1, 1'b0);
      check("fullpp_empty", int'(out_valid), 0);
      step(NOP, 1'b1, 1'b0);

      // push+pop holding one entry
      step(ldi(6), 1'b0, 1'b0);
      step(OUTI, 1'b0, 1'b0);
      step(ldi(8), 1'b0, 1'b0);
      step(OUTI, 1'b1, 1'b0);
      check("onepp_valid", int'(out_valid), 1);
      check("onepp_data", int'(out_data), 8);
      step(NOP, 1'b1, 1'b0);
      check("onepp_empty", int'(out_valid), 0);

      // JC/JMP opcodes leave state untouched
      step(ldi(4), 1'b0, 1'b0);
      step(MOVB, 1'b0, 1'b0);
      step(ldi(9), 1'b0, 1'b0);
      step(addi(9), 1'b0, 1'b0);
      step(OUTI, 1'b0, 1'b0);
      step(8'h7F, 1'b0, 1'b0);
      step(8'h95, 1'b0, 1'b0);
      step(8'hF3, 1'b0, 1'b0);
      step(8'h40, 1'b0, 1'b0);
      check("jmp_A", int'(dut.a_q), 2);
      check("jmp_B", int'(dut.b_q), 4);
      check("jmp_C", int'(alu_cout), 1);
      check("jmp_data", int'(out_data), 2);
      check("jmp_valid", int'(out_valid), 1);

      // reset beats OUT into a full FIFO
      step(ldi(3), 1'b0, 1'b0);
      step(OUTI, 1'b0, 1'b0);
      step(OUTI, 1'b1, 1'b1);
      check("rstpri_valid", int'(out_valid), 0);
      check("rstpri_ovf", int'(overflow), 0);
      check("rstpri_A", int'(dut.a_q), 0);
      check("rstpri_C", int'(alu_cout), 0);

      // mixed vector table, checked by the model
      begin
         logic [7:0] vi [12] = '{ldi(15), addi(15), OUTI, addi(0), OUTI, MOVB,
                                 addi(1), OUTI, OUTI, 8'hAA, ldi(12), OUTI};
         logic       vr [12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                                 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
         for (int k = 0; k < 12; k++) step(vi[k], vr[k], 1'b0);
         for (int k = 0; k < 4; k++) step(NOP, 1'b1, 1'b0);
      end
      check("final_empty", int'(out_valid), 0);

      @(negedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", nchk, nerr);
      $finish;
   end

endmodule

// File: doc/datapath.md
DATAPATH -- requirements
Module: datapath

Interface
REQ-001 Parameter DATA_WIDTH, default 4: width of accumulator A, register B, immediate and output data.
REQ-002 Parameter INST_WIDTH, default 8: instruction width; SHALL equal OPCODE_WIDTH + 2 + DATA_WIDTH.
REQ-003 Parameter OPCODE_WIDTH, default 2: opcode field width at inst[INST_WIDTH-1 -: OPCODE_WIDTH].
REQ-004 Parameter FIFO_DEPTH, fixed at 2: output buffer depth.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 inst  input  INST_WIDTH  current instruction from the control unit's instruction ROM.
REQ-008 alu_cout  output  1  registered carry flag C, fed back to the control unit for the conditional jump.
REQ-009 out_data  output  DATA_WIDTH  head entry of the output FIFO.
REQ-010 out_valid  output  1  FIFO non-empty.
REQ-011 out_ready  input  1  consumer accepts out_data when out_valid is high.
REQ-012 overflow  output  1  sticky flag: an OUT was dropped.

Function
REQ-013 Decode fields: opcode = inst[MSB -: OPCODE_WIDTH]; funct = the next 2 bits down; imm = inst[DATA_WIDTH-1:0].
REQ-014 Opcode 00 executes funct; opcodes 01 (JC), 10 and 11 (JMP) are no-ops for all datapath state.
REQ-015 funct 00 ADDI: {C,A} <= A + imm, computed at DATA_WIDTH+1 bits.
REQ-016 funct 01 LDI: A <= imm; C unchanged.
REQ-017 funct 10 MOVB: B <= A; A and C unchanged.
REQ-018 funct 11 OUT: push A into the output FIFO; A, B and C unchanged.
REQ-019 Every instruction completes in one cycle; results are visible the cycle after the edge.
REQ-020 alu_cout SHALL be driven directly from register C, with no combinational path from inst, so that the JC decision in the control unit uses the carry produced by earlier instructions.
REQ-021 FIFO: 2 entries, in-order delivery; out_data is valid only while out_valid is high.
REQ-022 A pop occurs on an edge where out_valid and out_ready are both high.
REQ-023 Push while not full: the entry is written.
REQ-024 Push while full without a pop on the same edge: the entry is dropped, overflow <= 1, and contents are unchanged.
REQ-025 Push and pop on the same edge while full: both take effect and the count stays at 2.
REQ-026 Push and pop on the same edge while holding one entry: the count stays at 1 and out_data becomes the pushed A value.
REQ-027 Push while empty: out_valid rises the next cycle; there is no fall-through in the same cycle.
REQ-028 Pop while empty is ignored.
REQ-029 overflow remains set until rst.
REQ-030 ADDI wrap-around: if A + imm >= 2^DATA_WIDTH, A takes the low bits and C = 1; otherwise C = 0.

Reset
REQ-031 While rst is high at an edge: A = 0, B = 0, C = 0, FIFO emptied (out_valid = 0), overflow = 0, out_data = 0.
REQ-032 rst takes priority over any instruction or pop on the same edge; an OUT issued in that cycle is lost and does not set overflow.
REQ-033 rst mid-sequence discards buffered FIFO data, with no partial state retained.

Verification
REQ-034 Reset, then LDI 9, ADDI 9 -> A = 2, alu_cout = 1; then ADDI 1 -> A = 3, alu_cout = 0.
REQ-035 LDI 5, MOVB, LDI 0 -> B = 5, A = 0, alu_cout unchanged from its prior value.
REQ-036 out_ready = 0; LDI 1, OUT, LDI 2, OUT, LDI 3, OUT -> out_valid = 1, overflow = 1; then out_ready = 1 -> outputs 1 then 2, then out_valid = 0.
REQ-037 FIFO full with out_ready = 1 and OUT of A = 7 on the same edge -> count stays 2, overflow = 0, 7 delivered third.
REQ-038 JC and JMP opcodes with arbitrary operand bits -> A, B, C and FIFO unchanged.
REQ-039 rst asserted with OUT and a full FIFO on the same edge -> out_valid = 0, overflow = 0, A = 0 on the next cycle.
